// File: rtl/clock_i2c_pkg.sv
// Shared definitions for the I2C temperature responder: FSM states,
// register map addresses and the default target address.
package clock_i2c_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CFG      = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection
// on the synchronized levels.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high in both cycles, so an SDA edge coincident with an SCL edge is data.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target exposing an ADT7420-style register map: temperature snapshot,
// a writable config register and a fixed ID byte behind an 8-bit pointer.
module i2c_temp_responder
  import clock_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter logic [7:0] ID_VALUE = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  output logic [7:0]  cfg_reg,
  output logic        busy,
  output logic        addr_hit
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [15:0] snap_q, snap_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        hit_q, hit_d;
  logic [7:0]  rd_byte;
  logic        byte_done;

  function automatic logic [7:0] reg_read(input logic [7:0] p, input logic [15:0] snap,
                                          input logic [7:0] cfg);
    case (p)
      REG_TEMP_MSB: return snap[15:8];
      REG_TEMP_LSB: return snap[7:0];
      REG_CFG:      return cfg;
      REG_ID:       return ID_VALUE;
      default:      return 8'h00;
    endcase
  endfunction

  assign rd_byte   = reg_read(ptr_q, snap_q, cfg_q);
  assign byte_done = (bitcnt_q == 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      ptr_q    <= '0;
      cfg_q    <= '0;
      snap_q   <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rw_q     <= rw_d;
      ack_q    <= ack_d;
      ptr_q    <= ptr_d;
      cfg_q    <= cfg_d;
      snap_q   <= snap_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    ptr_d    = ptr_q;
    cfg_d    = cfg_q;
    snap_d   = snap_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    hit_d    = 1'b0;

    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && !byte_done) begin
            shift_d  = {shift_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            bitcnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                hit_d    = 1'b1;
                busy_d   = 1'b1;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
                if (shift_q[0]) snap_d = temp_value;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d  = ST_IDLE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d    = shift_q;
              sda_oe_d = 1'b1;
              state_d  = ST_PTR_ACK;
            end else begin
              if (ptr_q == REG_CFG) cfg_d = shift_q;
              ptr_d    = ptr_q + 8'd1;
              sda_oe_d = 1'b1;
              state_d  = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise && !byte_done) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              // Pointer advances per byte sent; the ACK slot then loads from the new pointer.
              bitcnt_d = '0;
              ptr_d    = ptr_q + 8'd1;
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              tx_d     = {tx_q[6:0], tx_q[7]};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_s;
          end else if (scl_fall) begin
            if (ack_q) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign cfg_reg  = cfg_q;
  assign busy     = busy_q;
  assign addr_hit = hit_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bus-level bench: a bit-banged I2C master drives the responder, a behavioural
// register-map model predicts every slave response, a monitor scores them.
module tb_i2c_temp_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] temp_value = '0;
  logic [7:0]  cfg_reg;
  logic        busy;
  logic        addr_hit;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_temp_responder #(.DEV_ADDR(7'h4B), .ID_VALUE(8'hCB)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .temp_value (temp_value),
    .cfg_reg    (cfg_reg),
    .busy       (busy),
    .addr_hit   (addr_hit)
  );

  typedef struct {
    string       name;
    logic [15:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int    tests = 0;
  int    fails = 0;

  int    hit_cnt = 0;
  bit    oe_seen = 1'b0;
  always @(posedge clk) begin
    if (addr_hit) hit_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  // Reference model state
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] m_cfg = 8'h00;
  logic [7:0] wbuf[$];

  function automatic logic [7:0] m_read(input logic [7:0] p, input logic [15:0] snap);
    if (p == 8'h00) return snap[15:8];
    if (p == 8'h01) return snap[7:0];
    if (p == 8'h03) return m_cfg;
    if (p == 8'h0B) return 8'hCB;
    return 8'h00;
  endfunction

  function automatic void push_exp(input string n, input logic [15:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endfunction

  function automatic void push_obs(input string n, input logic [15:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    obs_q.push_back(it);
  endfunction

  initial begin : monitor
    item_t o, e;
    forever begin
      @(negedge clk);
      while (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s: got %h, no expected value queued", o.name, o.val);
        end else begin
          e = exp_q.pop_front();
          if (e.name != o.name || e.val !== o.val)begin
            fails++;
            $display("FAIL %s: got %h, expected %s=%h", o.name, o.val, e.name, e.val);
          end
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; entered and left with SCL low. simul moves the SDA change onto the SCL rise.
  task automatic bit_cycle(input logic drive, input bit simul, output logic seen);
    wclk(3);
    if (!simul) sda_m = drive;
    wclk(7);
    if (simul) sda_m = drive;
    scl_m = 1'b1;
    wclk(6);
    seen = sda_line;
    wclk(6);
    scl_m = 1'b0;
  endtask

  task automatic send_start();
    if (scl_m == 1'b0) begin
      wclk(3);
      sda_m = 1'b1;
      wclk(7);
      scl_m = 1'b1;
    end else begin
      sda_m = 1'b1;
    end
    wclk(8);
    sda_m = 1'b0;
    wclk(10);
    scl_m = 1'b0;
  endtask

  task automatic send_stop();
    wclk(3);
    sda_m = 1'b0;
    wclk(7);
    scl_m = 1'b1;
    wclk(8);
    sda_m = 1'b1;
    wclk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], ($urandom_range(0, 3) == 0), seen);
    bit_cycle(1'b1, 1'b0, seen);
    ack = ~seen;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, seen);
      b[i] = seen;
    end
    bit_cycle(~mack, 1'b0, seen);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    logic ack;
    int   hc0;
    bit   match;
    match   = (a == 7'h4B);
    hc0     = hit_cnt;
    oe_seen = 1'b0;
    push_exp("addr_ack", {15'd0, match});
    write_byte({a, rw}, ack);
    push_obs("addr_ack", {15'd0, ack});
    push_exp("addr_hit_pulses", match ? 16'd1 : 16'd0);
    push_obs("addr_hit_pulses", 16'(hit_cnt - hc0));
    push_exp("busy_after_addr", {15'd0, match});
    push_obs("busy_after_addr", {15'd0, busy});
    if (!match) begin
      push_exp("sda_oe_nomatch", 16'd0);
      push_obs("sda_oe_nomatch", {15'd0, oe_seen});
    end
  endtask

  // Address, pointer, then the bytes in wbuf; STOP optional (else a repeated START follows).
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input bit stop_after);
    logic ack;
    send_start();
    send_addr(a, 1'b0);
    if (a == 7'h4B) begin
      push_exp("ptr_ack", 16'd1);
      write_byte(p, ack);
      push_obs("ptr_ack", {15'd0, ack});
      m_ptr = p;
      while (wbuf.size() != 0) begin
        logic [7:0] d;
        d = wbuf.pop_front();
        push_exp("wdata_ack", 16'd1);
        write_byte(d, ack);
        push_obs("wdata_ack", {15'd0, ack});
        if (m_ptr == 8'h03) m_cfg = d;
        m_ptr = m_ptr + 8'd1;
      end
    end
    wbuf.delete();
    if (stop_after || a != 7'h4B) begin
      send_stop();
      wclk(4);
      push_exp("cfg_reg", {8'd0, m_cfg});
      push_obs("cfg_reg", {8'd0, cfg_reg});
      push_exp("busy_after_stop", 16'd0);
      push_obs("busy_after_stop", {15'd0, busy});
    end
  endtask

  // Read n bytes; temp_value is t0 at the address phase and switches to t1 after the first byte.
  task automatic do_read(input int n, input logic [15:0] t0, input logic [15:0] t1);
    logic [7:0]  b;
    logic [15:0] snap;
    temp_value = t0;
    snap       = t0;
    send_start();
    send_addr(7'h4B, 1'b1);
    for (int i = 0; i < n; i++) begin
      push_exp("rdata", {8'd0, m_read(m_ptr, snap)});
      m_ptr = m_ptr + 8'd1;
      read_byte(i < n - 1, b);
      push_obs("rdata", {8'd0, b});
      if (i == 0) temp_value = t1;
    end
    send_stop();
    wclk(4);
    push_exp("busy_after_stop", 16'd0);
    push_obs("busy_after_stop", {15'd0, busy});
  endtask

  initial begin : stimulus
    logic seen;
    logic [7:0] pchoices[5];
    rst = 1'b1;
    wclk(4);
    push_exp("rst_sda_oe", 16'd0);   push_obs("rst_sda_oe", {15'd0, sda_oe});
    push_exp("rst_busy", 16'd0);     push_obs("rst_busy", {15'd0, busy});
    push_exp("rst_addr_hit", 16'd0); push_obs("rst_addr_hit", {15'd0, addr_hit});
    push_exp("rst_cfg", 16'd0);      push_obs("rst_cfg", {8'd0, cfg_reg});
    rst = 1'b0;
    wclk(4);

    // Config write
    wbuf.push_back(8'hA5);
    do_write(7'h4B, 8'h03, 1'b1);

    // Pointer write, repeated START, two-byte temperature read
    do_write(7'h4B, 8'h00, 1'b0);
    do_read(2, 16'h0C80, 16'h0C80);

    // Foreign address is ignored
    wbuf.push_back(8'h5A);
    do_write(7'h48, 8'h03, 1'b1);

    // ID register and walk past it
    do_write(7'h4B, 8'h0B, 1'b1);
    do_read(3, 16'h1234, 16'h1234);
    push_exp("ptr_after_id_read", 16'h000E);
    push_obs("ptr_after_id_read", {8'd0, dut.ptr_q});

    // Temperature changes between MSB and LSB of one read
    do_write(7'h4B, 8'h00, 1'b1);
    do_read(2, 16'h0C80, 16'h0D00);

    // Pointer wrap from 0xFF
    do_write(7'h4B, 8'hFF, 1'b1);
    do_read(3, 16'hBEEF, 16'h0000);

    // Randomized transactions; pointer persists between them
    pchoices = '{8'h00, 8'h01, 8'h03, 8'h0B, 8'hFE};
    for (int t = 0; t < 14; t++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      if (kind <= 1) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) wbuf.push_back(8'($urandom));
        do_write(7'h4B, pchoices[$urandom_range(0, 4)], 1'b1);
      end else if (kind == 2) begin
        wbuf.push_back(8'($urandom));
        do_write(7'($urandom_range(0, 127)) ^ 7'h01 ^ ((7'($urandom) == 7'h4A) ? 7'h01 : 7'h00)
                   | 7'h00, 8'($urandom), 1'b1);
      end else if (kind == 3) begin
        do_write(7'h4B, pchoices[$urandom_range(0, 4)], 1'b0);
        do_read(int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom));
      end else begin
        do_read(int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom));
      end
    end

    // Reset while the responder is driving a 0 bit of the ID byte (0xCB: third bit is 0)
    do_write(7'h4B, 8'h0B, 1'b1);
    send_start();
    send_addr(7'h4B, 1'b1);
    bit_cycle(1'b1, 1'b0, seen);
    bit_cycle(1'b1, 1'b0, seen);
    wclk(6);
    push_exp("oe_before_rst", 16'd1);
    push_obs("oe_before_rst", {15'd0, sda_oe});
    #2 rst = 1'b1;
    #1;
    push_exp("oe_async_rst", 16'd0);
    push_obs("oe_async_rst", {15'd0, sda_oe});
    wclk(3);
    rst   = 1'b0;
    m_ptr = 8'h00;
    m_cfg = 8'h00;
    wclk(3);
    push_exp("cfg_after_rst", 16'd0);
    push_obs("cfg_after_rst", {8'd0, cfg_reg});
    wbuf.push_back(8'h3C);
    do_write(7'h4B, 8'h03, 1'b1);
    do_read(1, 16'h0000, 16'h0000);

    wclk(10);
    while (exp_q.size() != 0) begin
      item_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: no response observed, expected %h", e.name, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_temp_responder.md
I2C_TEMP_RESPONDER -- requirements
Module: i2c_temp_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h4B, is the 7-bit target address this block answers to.
REQ-002 Parameter ID_VALUE, default 8'hCB, is the value returned from register 0x0B.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 scl_i  input  1  raw I2C SCL pin level; asynchronous to clk.
REQ-006 sda_i  input  1  raw I2C SDA pin level; asynchronous to clk.
REQ-007 sda_oe  output  1  1 pulls SDA low; 0 releases SDA (open-drain).
REQ-008 temp_value  input  16  live 13-bit temperature in ADT7420 format, left-justified in bits [15:3].
REQ-009 cfg_reg  output  8  last value written to register 0x03.
REQ-010 busy  output  1  high from a START addressed to DEV_ADDR until the next STOP or START.
REQ-011 addr_hit  output  1  one-cycle pulse when an address byte matches DEV_ADDR.

Function
REQ-012 scl_i and sda_i SHALL each pass a 2-flop synchronizer before any use; edges are detected on the synchronized level, so an event is seen 3 clk after the pin changes.
REQ-013 START SHALL be detected as a synchronized SDA fall while SCL is high; STOP as an SDA rise while SCL is high.
REQ-014 Data bits SHALL be sampled on a synchronized SCL rise; sda_oe SHALL change only on a synchronized SCL fall.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 A START in any state, including a repeated START, SHALL reset the bit counter and enter ADDR; a STOP in any state SHALL enter IDLE and release sda_oe.
REQ-017 ADDR: shift 8 bits MSB first; on a match with DEV_ADDR, pulse addr_hit and drive ACK low for the 9th SCL; on a mismatch, release SDA and enter IDLE until the next START.
REQ-018 A matched write (R/W=0) SHALL go ADDR_ACK->PTR; the received byte loads the pointer and is ACKed; later bytes go to WDATA.
REQ-019 WDATA: a byte written with pointer 0x03 SHALL load cfg_reg; writes to every other pointer are ACKed and discarded; the pointer increments after each data byte.
REQ-020 A matched read (R/W=1) SHALL snapshot temp_value into a 16-bit holding register in the ADDR_ACK cycle, so MSB and LSB come from the same sample.
REQ-021 Read map: 0x00 snapshot[15:8]; 0x01 snapshot[7:0]; 0x03 cfg_reg; 0x0B ID_VALUE; every other pointer returns 8'h00.
REQ-022 RDATA: drive the bit MSB first; 0 asserts sda_oe and 1 releases it; release SDA for the master ACK bit.
REQ-023 RDATA_ACK: a master ACK (SDA low) increments the pointer modulo 256 and loads the next byte; a NACK enters IDLE with SDA released.
REQ-024 The pointer SHALL be 8 bits and SHALL wrap from 8'hFF to 8'h00.
REQ-025 The pointer SHALL persist across transactions, so a read without a preceding pointer write starts at the last pointer.
REQ-026 If SCL and SDA change in the same synchronized cycle, the block SHALL treat it as a data-phase change, not START or STOP.

Reset
REQ-027 On rst high, asynchronously: state=IDLE, sda_oe=0, busy=0, addr_hit=0, cfg_reg=8'h00, pointer=8'h00, snapshot=16'h0000, synchronizers=1'b1.
REQ-028 Reset mid-transaction SHALL release SDA immediately; the block then waits for a fresh START.

Structure
REQ-029 A shared package clock_i2c_pkg SHALL hold the state enum, register addresses (REG_TEMP_MSB=0x00, REG_TEMP_LSB=0x01, REG_CFG=0x03, REG_ID=0x0B) and the default device address.
REQ-030 The synchronizer and the START/STOP/SCL-edge detection SHALL form one sub-module, i2c_line_sync, instantiated once.

Verification
REQ-031 Write 0x96, 0x03, 0xA5, then STOP -> every byte ACKed; cfg_reg=8'hA5; busy drops after STOP.
REQ-032 temp_value=16'h0C80; write 0x96, 0x00, repeated START, 0x97, read 2 bytes with ACK then NACK -> SDA carries 0x0C then 0x80; addr_hit pulses twice.
REQ-033 Address 0x90 (0x48, W) -> no ACK, sda_oe stays 0, addr_hit stays 0, cfg_reg unchanged.
REQ-034 Pointer 0x0B, read 3 bytes -> 0xCB, 0x00, 0x00; pointer ends at 0x0E.
REQ-035 temp_value changes from 16'h0C80 to 16'h0D00 between the MSB and LSB bits of one read -> master receives 0x0C, 0x80.
REQ-036 Assert rst while driving a 0 data bit -> sda_oe=0 in the same cycle; the next START and address are ACKed normally.
